// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with the HI/LO registers; one shared 33-bit add/sub path.
// Optional MTHI/MTLO write port is enabled by defining MDU_HILO_WRITE_EN.
//
// state | meaning
// IDLE  | waiting for start_i; HI/LO writes accepted here when enabled
// CALC  | one shift-add or restoring-subtract iteration per cycle
// FIX   | sign correction of product / quotient / remainder
// DONE  | results visible on hi_o/lo_o, done_o pulse
module mdu_ctrl #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
`ifdef MDU_HILO_WRITE_EN
  input  logic [1:0]       hilo_we_i,
  input  logic [Width-1:0] hilo_wdata_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CntW    = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [Width-1:0] m_q, m_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] sh_q, sh_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;

  logic             a_neg, b_neg, b_zero;
  logic [Width-1:0] a_mag, b_mag;
  logic [Width:0]   path_a, path_b, path_y;
  logic             path_sub;
  logic [2*Width-1:0] prod_fix;
  logic [Width-1:0] quot_fix, rem_fix;

  assign a_neg  = ~op_i[0] & a_i[Width-1];
  assign b_neg  = ~op_i[0] & b_i[Width-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign b_zero = (b_i == '0);

  // Divide: shifted {rem, quot MSB} minus divisor; multiply: acc plus multiplicand when LSB set.
  always_comb begin
    path_a   = {1'b0, acc_q};
    path_b   = '0;
    path_sub = 1'b0;
    if (is_div_q) begin
      path_a   = {acc_q, sh_q[Width-1]};
      path_b   = {1'b0, m_q};
      path_sub = 1'b1;
    end else if (sh_q[0]) begin
      path_b = {1'b0, m_q};
    end
    path_y = path_sub ? (path_a - path_b) : (path_a + path_b);
  end

  assign prod_fix = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
  assign quot_fix = neg_q ? -sh_q : sh_q;
  assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    m_d       = m_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
`ifdef MDU_HILO_WRITE_EN
        if (hilo_we_i[1]) hi_d = hilo_wdata_i;
        if (hilo_we_i[0]) lo_d = hilo_wdata_i;
`endif
        if (start_i) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = op_i[1];
          // Divide by zero leaves the all-ones quotient unsigned; remainder fix restores a_i.
          neg_d     = (a_neg ^ b_neg) & ~(op_i[1] & b_zero);
          rem_neg_d = a_neg;
          acc_d     = '0;
          m_d       = op_i[1] ? b_mag : a_mag;
          sh_d      = op_i[1] ? a_mag : b_mag;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_d = path_y[Width] ? path_a[Width-1:0] : path_y[Width-1:0];
          sh_d  = {sh_q[Width-2:0], ~path_y[Width]};
        end else begin
          acc_d = path_y[Width:1];
          sh_d  = {path_y[0], sh_q[Width-1:1]};
        end
        if (cnt_q == CntLast) state_d = S_FIX;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*Width-1:Width];
          lo_d = prod_fix[Width-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      m_q       <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: cycle-level reference model compared every cycle, plus literal result checks.
// Define MDU_HILO_WRITE_EN to also exercise the MTHI/MTLO port.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_HILO_WRITE_EN
  logic [1:0]  we;
  logic [31:0] wdata;
`endif

  mdu_ctrl #(.Width(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
`ifdef MDU_HILO_WRITE_EN
    .hilo_we_i(we), .hilo_wdata_i(wdata),
`endif
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Arithmetic reference: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    int     qx, qy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; r = p; end
      2'b01: r = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          qx = $signed(x);
          qy = $signed(y);
          r  = {32'(qx % qy), 32'(qx / qy)};
        end
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // m_rem: cycles left until idle; value 1 marks the done cycle.
  int          m_rem   = 0;
  bit          m_valid = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_rem = 0; m_hi = '0; m_lo = '0; m_valid = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 1) begin m_hi = p_hi; m_lo = p_lo; end
    end else begin
`ifdef MDU_HILO_WRITE_EN
      if (we[1]) m_hi = wdata;
      if (we[0]) m_lo = wdata;
`endif
      if (start) begin
        m_rem = 34;
        {p_hi, p_lo} = ref_result(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {63'd0, busy}, {63'd0, m_rem > 0});
      chk("done", {63'd0, done}, {63'd0, m_rem == 1});
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int t0, seen;
    op = o; a = x; b = y; start = 1'b1;
    t0 = cyc;
    step;
    start = 1'b0;
    seen = -1;
    for (int i = 0; i < 60 && seen < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = cyc;
    end
    chk({nm, "_done_cycle"}, 64'(seen), 64'(t0 + 34));
    chk({nm, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({nm, "_lo"}, {32'd0, lo}, {32'd0, el});
    step;
  endtask

  initial begin
    int t0, seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef MDU_HILO_WRITE_EN
    we = 2'b00; wdata = '0;
`endif
    step; step;
    rst = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    step;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_neg7by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Busy-time starts are dropped, including in the done cycle.
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    t0 = cyc;
    step;
    start = 1'b0;
    while (cyc < t0 + 5) step;
    op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1;
    step;
    start = 1'b0;
    while (cyc < t0 + 34) step;
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    chk("ignore_done_flag", {63'd0, done}, 64'd1);
    chk("divu_100by7_lo", {32'd0, lo}, 64'd14);
    chk("divu_100by7_hi", {32'd0, hi}, 64'd2);
    step;
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    step;
    start = 1'b0;
    seen = -1;
    for (int i = 0; i < 60 && seen < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = cyc;
    end
    chk("second_done_cycle", 64'(seen), 64'(t0 + 69));
    chk("second_lo", {32'd0, lo}, 64'd15);
    chk("second_hi", {32'd0, hi}, 64'd0);
    step;

    // Mid-operation reset.
    run_op("divu_prime", 2'b11, 32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678);
    op = 2'b01; a = 32'd1000; b = 32'd1000; start = 1'b1;
    t0 = cyc;
    step;
    start = 1'b0;
    while (cyc < t0 + 20) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_hi", {32'd0, hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, lo}, 64'd0);
    repeat (40) step;

`ifdef MDU_HILO_WRITE_EN
    we = 2'b11; wdata = 32'hAA;
    step;
    we = 2'b00;
    chk("mthilo_hi", {32'd0, hi}, 64'hAA);
    chk("mthilo_lo", {32'd0, lo}, 64'hAA);
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    step;
    start = 1'b0;
    repeat (3) step;
    we = 2'b11; wdata = 32'h55;
    step;
    we = 2'b00;
    chk("mthilo_busy_hi", {32'd0, hi}, 64'hAA);
    chk("mthilo_busy_lo", {32'd0, lo}, 64'hAA);
    repeat (40) step;
    chk("mthilo_after_hi", {32'd0, hi}, 64'd0);
    chk("mthilo_after_lo", {32'd0, lo}, 64'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
